mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one synchronous single-port 32-bit memory (dmem-style BRAM, 1-cycle read latency) between two masters.
- Requester 0 is the Riscv151 data port; requester 1 is the program loader/debug master that preloads memory before and between CPU runs.
- Grants one access per cycle, round-robin, with a bounded burst hold.
- Routes the read data back to the master that issued the read.

Parameters:
- ADDR_WIDTH, 14, word-address width of the shared memory.
- MAX_BURST, 4, max consecutive grants to one master while the other is requesting (>=1).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous reset, active-high.
- r0_req  input  1  requester 0 access request, held until granted.
- r0_we  input  4  requester 0 byte write mask; 0 = read.
- r0_addr  input  ADDR_WIDTH  requester 0 word address.
- r0_wdata  input  32  requester 0 write data.
- r0_gnt  output  1  requester 0 access accepted this cycle.
- r0_rvalid  output  1  requester 0 read data valid.
- r0_rdata  output  32  requester 0 read data.
- r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata: identical set for requester 1.
- mem_en  output  1  memory port enable.
- mem_we  output  4  memory byte write enable.
- mem_addr  output  ADDR_WIDTH  memory address.
- mem_din  output  32  memory write data.
- mem_dout  input  32  memory read data, valid 1 cycle after mem_en with mem_we==0.

Behaviour:
- Grant logic:
  - Combinational from req, the priority pointer `last` and the burst counter `bcnt`.
  - At most one gnt per cycle. gnt implies the access is issued to memory the same cycle.
  - A master must hold req/we/addr/wdata stable until it sees gnt.
- Arbitration rules:
  - Only one master requesting: that master is granted, every cycle, with no burst limit.
  - Both requesting: the master != `last` wins, unless `last` is still under its burst allowance (bcnt < MAX_BURST), in which case `last` keeps the grant.
  - With MAX_BURST=1 this reduces to strict alternation.
- Priority pointer and burst counter update on each granted cycle:
  - Same master as `last`: bcnt <= bcnt+1, saturating at MAX_BURST.
  - Different master: last <= new master, bcnt <= 1.
  - No grant (idle cycle): bcnt <= 0 and `last` is held, so a burst is broken by any idle cycle.
- Memory mux:
  - mem_en = r0_gnt | r1_gnt; mem_we, mem_addr, mem_din come from the granted master.
  - No grant: mem_en=0, mem_we=0, address/data don't-care (drive 0).
- Read return:
  - A 1-bit registered tag plus a `pend` flag records a granted read (we==0).
  - The next cycle, rX_rvalid=1 for the tagged master only, and rX_rdata = mem_dout.
  - Writes produce no rvalid.
  - Read latency is exactly 1 cycle after gnt. Back-to-back reads give rvalid on consecutive cycles, possibly to alternating masters.
  - rdata of the non-tagged master is held at 0.
- Reset values (asynchronous):
  - gnt 0, rvalid 0, rdata 0, mem_en 0.
  - last = 1, so requester 0 wins first contention.
  - bcnt = 0, pend = 0.
- Reset mid-operation:
  - An in-flight read is dropped and no rvalid is issued after reset deasserts.
  - No grant while rst=1, even if req is high.
- Simultaneous read-return and new grant are independent; both occur in the same cycle.
- A write and a read to the same address on consecutive cycles: the read returns the written data (memory is write-first). No forwarding is done in this block.

Test Plan:
- Reset hold, then r0 alone reads 0x10 for 3 cycles -> r0_gnt=1 each cycle; r0_rvalid on cycles 1-3 after each gnt with mem contents; r1 signals stay 0.
- Both req high from reset, MAX_BURST=4, reads -> grants 0,0,0,0,1,1,1,1,0... ; each rvalid goes to the correct master exactly 1 cycle later.
- r0 write we=4'b1111 addr 0x20 data 0xDEADBEEF, then r1 read 0x20 -> mem_we=4'hF on r0 grant; r1_rdata=0xDEADBEEF next cycle after r1 gnt; no rvalid for the write.
- MAX_BURST=1, both requesting 6 cycles -> strict alternation 0,1,0,1,0,1.
- r1 bursts 2 grants, one idle cycle, then both request -> r0 wins (last=1, bcnt reset), showing the idle cycle resets bcnt.
- Assert rst in the cycle after an r0 read grant -> r0_rvalid never asserts; after release with both requesting, r0 is granted first.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters, the shared single-port memory and the arbiter.
// The arbiter connects through the slave view; the environment uses the master view.
`timescale 1ns/1ps
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 14
);
    logic                  r0_req;
    logic [3:0]            r0_we;
    logic [ADDR_WIDTH-1:0] r0_addr;
    logic [31:0]           r0_wdata;
    logic                  r0_gnt;
    logic                  r0_rvalid;
    logic [31:0]           r0_rdata;

    logic                  r1_req;
    logic [3:0]            r1_we;
    logic [ADDR_WIDTH-1:0] r1_addr;
    logic [31:0]           r1_wdata;
    logic                  r1_gnt;
    logic                  r1_rvalid;
    logic [31:0]           r1_rdata;

    logic                  mem_en;
    logic [3:0]            mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_din;
    logic [31:0]           mem_dout;

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata,
        output r0_gnt, r0_rvalid, r0_rdata,
        input  r1_req, r1_we, r1_addr, r1_wdata,
        output r1_gnt, r1_rvalid, r1_rdata,
        output mem_en, mem_we, mem_addr, mem_din,
        input  mem_dout
    );

    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata,
        input  r0_gnt, r0_rvalid, r0_rdata,
        output r1_req, r1_we, r1_addr, r1_wdata,
        input  r1_gnt, r1_rvalid, r1_rdata,
        input  mem_en, mem_we, mem_addr, mem_din,
        output mem_dout
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one 1-cycle-latency memory port between the CPU data port (r0)
// and the loader/debug master (r1), with a bounded burst hold and tagged read-data return.
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 14,
    parameter int MAX_BURST  = 4
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX  = BW'(MAX_BURST);
    localparam logic [BW-1:0] BURST_ONE  = BW'(1);
    localparam logic [BW-1:0] BURST_ZERO = BW'(0);

    logic                  last_q, last_d;
    logic [BW-1:0]         bcnt_q, bcnt_d;
    logic                  pend_q, pend_d;
    logic                  tag_q, tag_d;
    logic                  keep_s;
    logic                  gnt0_s, gnt1_s, gnt_any_s;
    logic                  mem_en_s;
    logic [3:0]            mem_we_s;
    logic [ADDR_WIDTH-1:0] mem_addr_s;
    logic [31:0]           mem_din_s;
    logic                  rvalid0_s, rvalid1_s;

    // Grant decision; bcnt==0 means no burst in progress, so the non-last master wins contention
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        keep_s = (bcnt_q != BURST_ZERO) && (bcnt_q < BURST_MAX);
        if (rst) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (bus.r0_req && bus.r1_req) begin
            if (keep_s) begin
                gnt0_s = ~last_q;
                gnt1_s = last_q;
            end else begin
                gnt0_s = last_q;
                gnt1_s = ~last_q;
            end
        end else if (bus.r0_req) begin
            gnt0_s = 1'b1;
        end else if (bus.r1_req) begin
            gnt1_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Memory port mux from the granted master
    always_comb begin
        mem_en_s   = 1'b0;
        mem_we_s   = 4'b0000;
        mem_addr_s = '0;
        mem_din_s  = 32'h0000_0000;
        if (gnt0_s) begin
            mem_en_s   = 1'b1;
            mem_we_s   = bus.r0_we;
            mem_addr_s = bus.r0_addr;
            mem_din_s  = bus.r0_wdata;
        end else if (gnt1_s) begin
            mem_en_s   = 1'b1;
            mem_we_s   = bus.r1_we;
            mem_addr_s = bus.r1_addr;
            mem_din_s  = bus.r1_wdata;
        end else begin
            mem_en_s   = 1'b0;
        end
    end

    // Next priority pointer, burst count and read-return tag
    always_comb begin
        last_d    = last_q;
        bcnt_d    = bcnt_q;
        pend_d    = 1'b0;
        tag_d     = tag_q;
        gnt_any_s = gnt0_s | gnt1_s;
        if (gnt_any_s) begin
            pend_d = (mem_we_s == 4'b0000);
            tag_d  = gnt1_s;
            if (gnt1_s == last_q) begin
                if (bcnt_q == BURST_MAX) begin
                    bcnt_d = bcnt_q;
                end else begin
                    bcnt_d = bcnt_q + BURST_ONE;
                end
            end else begin
                last_d = gnt1_s;
                bcnt_d = BURST_ONE;
            end
        end else begin
            bcnt_d = BURST_ZERO;
        end
    end

    // State registers; reset drops any in-flight read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
            bcnt_q <= BURST_ZERO;
            pend_q <= 1'b0;
            tag_q  <= 1'b0;
        end else begin
            last_q <= last_d;
            bcnt_q <= bcnt_d;
            pend_q <= pend_d;
            tag_q  <= tag_d;
        end
    end

    assign rvalid0_s = pend_q & ~tag_q;
    assign rvalid1_s = pend_q & tag_q;

    assign bus.r0_gnt    = gnt0_s;
    assign bus.r1_gnt    = gnt1_s;
    assign bus.r0_rvalid = rvalid0_s;
    assign bus.r1_rvalid = rvalid1_s;
    assign bus.r0_rdata  = rvalid0_s ? bus.mem_dout : 32'h0000_0000;
    assign bus.r1_rdata  = rvalid1_s ? bus.mem_dout : 32'h0000_0000;
    assign bus.mem_en    = mem_en_s;
    assign bus.mem_we    = mem_we_s;
    assign bus.mem_addr  = mem_addr_s;
    assign bus.mem_din   = mem_din_s;
endmodule
